// File: rtl/freq_pkg.sv
// Shared state encoding and default widths for the frequency counter sequencer.
package freq_pkg;

  localparam int STATE_W    = 3;
  localparam int CNT_W_DEF  = 32;
  localparam int GATE_W_DEF = 24;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_ARM    = 3'd2,
    S_GATE   = 3'd3,
    S_CLOSE  = 3'd4,
    S_SETTLE = 3'd5,
    S_REPORT = 3'd6
  } state_t;

endpackage

// File: rtl/freq_gate_timer.sv
// Loadable down-counter that saturates at zero.
module freq_gate_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         en,
  output logic         zero,
  output logic         last
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (en && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);
  assign last = (count == W'(1));

endmodule

// File: rtl/freq_meas_sequencer.sv
// Gate/measurement sequencer of the reciprocal frequency counter.
// Build option: CONTINUOUS_MODE_EN repeats measurements until start_i in REPORT.
module freq_meas_sequencer
  import freq_pkg::*;
#(
  parameter int CNT_W          = CNT_W_DEF,
  parameter int GATE_W         = GATE_W_DEF,
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int SETTLE_CYCLES  = 4
) (
  input  logic               clk_i,
  input  logic               async_rst_i,
  input  logic               start_i,
  input  logic [GATE_W-1:0]  gate_len_i,
  input  logic               sig_edge_i,
  input  logic [CNT_W-1:0]   sig_count_i,
  input  logic [CNT_W-1:0]   ref_count_i,
  output logic               cnt_clr_o,
  output logic               gate_o,
  output logic               res_valid_o,
  input  logic               res_ready_i,
  output logic [CNT_W-1:0]   res_sig_o,
  output logic [CNT_W-1:0]   res_ref_o,
  output logic               timeout_o,
  output logic               busy_o,
  output logic [STATE_W-1:0] state_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  state_t state, next;

  logic [GATE_W-1:0] gate_len;
  logic [SW-1:0]     settle_cnt;

  logic gt_load, gt_en, gt_zero, gt_last;
  logic to_load, to_en, to_zero, to_last_unused;
  logic latch_len, clr_tmo, set_tmo;
  logic zero_res, sample;
  logic settle_clr, settle_inc;
  logic stop;

  freq_gate_timer #(.W(GATE_W)) u_gate_timer (
    .clk   (clk_i),
    .rst_n (async_rst_i),
    .load  (gt_load),
    .value (gate_len),
    .en    (gt_en),
    .zero  (gt_zero),
    .last  (gt_last)
  );

  freq_gate_timer #(.W(TW)) u_tmo_timer (
    .clk   (clk_i),
    .rst_n (async_rst_i),
    .load  (to_load),
    .value (TW'(TIMEOUT_CYCLES)),
    .en    (to_en),
    .zero  (to_zero),
    .last  (to_last_unused)
  );

`ifdef CONTINUOUS_MODE_EN
  logic stop_q;

  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      stop_q <= 1'b0;
    end else if (state != S_REPORT) begin
      stop_q <= 1'b0;
    end else if (start_i) begin
      stop_q <= 1'b1;
    end
  end

  assign stop = stop_q | start_i;
`else
  assign stop = 1'b1;
`endif

  always_comb begin
    next       = state;
    gt_load    = 1'b0;
    gt_en      = 1'b0;
    to_load    = 1'b0;
    to_en      = 1'b0;
    latch_len  = 1'b0;
    clr_tmo    = 1'b0;
    set_tmo    = 1'b0;
    zero_res   = 1'b0;
    sample     = 1'b0;
    settle_clr = 1'b0;
    settle_inc = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start_i) begin
          latch_len = 1'b1;
          clr_tmo   = 1'b1;
          next      = S_CLEAR;
        end
      end
      S_CLEAR: begin
        to_load = 1'b1;
        next    = S_ARM;
      end
      S_ARM: begin
        if (sig_edge_i) begin
          gt_load = 1'b1;
          next    = S_GATE;
        end else if (to_zero) begin
          set_tmo  = 1'b1;
          zero_res = 1'b1;
          next     = S_REPORT;
        end else begin
          to_en = 1'b1;
        end
      end
      S_GATE: begin
        gt_en = 1'b1;
        if (gt_last || gt_zero) begin
          to_load = 1'b1;
          next    = S_CLOSE;
        end
      end
      S_CLOSE: begin
        if (sig_edge_i) begin
          settle_clr = 1'b1;
          next       = S_SETTLE;
        end else if (to_zero) begin
          set_tmo    = 1'b1;
          settle_clr = 1'b1;
          next       = S_SETTLE;
        end else begin
          to_en = 1'b1;
        end
      end
      S_SETTLE: begin
        if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
          sample = 1'b1;
          next   = S_REPORT;
        end else begin
          settle_inc = 1'b1;
        end
      end
      S_REPORT: begin
        if (res_ready_i) begin
          if (stop) begin
            next = S_IDLE;
          end else begin
            clr_tmo = 1'b1;
            next    = S_CLEAR;
          end
        end
      end
      default: next = S_IDLE;
    endcase
  end

  // Control outputs are decoded from the next state so they stay registered.
  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      state       <= S_IDLE;
      gate_o      <= 1'b0;
      cnt_clr_o   <= 1'b0;
      busy_o      <= 1'b0;
      res_valid_o <= 1'b0;
    end else begin
      state       <= next;
      gate_o      <= (next == S_GATE) || (next == S_CLOSE);
      cnt_clr_o   <= (next == S_CLEAR);
      busy_o      <= (next != S_IDLE);
      res_valid_o <= (next == S_REPORT);
    end
  end

  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      gate_len   <= '0;
      settle_cnt <= '0;
      timeout_o  <= 1'b0;
      res_sig_o  <= '0;
      res_ref_o  <= '0;
    end else begin
      if (latch_len) begin
        gate_len <= (gate_len_i == '0) ? GATE_W'(1) : gate_len_i;
      end
      if (settle_clr) begin
        settle_cnt <= '0;
      end else if (settle_inc) begin
        settle_cnt <= settle_cnt + 1'b1;
      end
      if (clr_tmo) begin
        timeout_o <= 1'b0;
      end else if (set_tmo) begin
        timeout_o <= 1'b1;
      end
      if (zero_res) begin
        res_sig_o <= '0;
        res_ref_o <= '0;
      end else if (sample) begin
        res_sig_o <= sig_count_i;
        res_ref_o <= ref_count_i;
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_freq_meas_sequencer.sv
// Randomized self-checking bench for freq_meas_sequencer.
module tb_freq_meas_sequencer;

  localparam int TMO = 50;
  localparam int SET = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] glen = '0;
  logic        sig_edge = 1'b0;
  logic [31:0] sigc = '0;
  logic [31:0] refc = '0;
  logic        ready = 1'b0;
  logic        cnt_clr, gate, valid, tmo_flag, busy;
  logic [31:0] res_sig, res_ref;
  logic [2:0]  state;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int mode = 0;
  int period = 5;
  int prob = 30;
  int fire_at = -1;
  bit const_cnt = 1'b0;
  int gate_cnt = 0;
  int clr_cnt = 0;
  int edge_q[$];

  freq_meas_sequencer #(
    .CNT_W(32), .GATE_W(24), .TIMEOUT_CYCLES(TMO), .SETTLE_CYCLES(SET)
  ) dut (
    .clk_i(clk), .async_rst_i(rst_n), .start_i(start),
    .gate_len_i(glen), .sig_edge_i(sig_edge),
    .sig_count_i(sigc), .ref_count_i(refc),
    .cnt_clr_o(cnt_clr), .gate_o(gate), .res_valid_o(valid),
    .res_ready_i(ready), .res_sig_o(res_sig), .res_ref_o(res_ref),
    .timeout_o(tmo_flag), .busy_o(busy), .state_o(state)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sfn(int n);
    return const_cnt ? 32'd7 : 32'(n * 3 + 17);
  endfunction

  function automatic logic [31:0] rfn(int n);
    return const_cnt ? 32'd123 : 32'(n * 1000 + 5);
  endfunction

  // Stimulus generator: cyc names the clock interval after each posedge.
  initial begin
    bit e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (mode)
        1: e = (cyc % period) == 0;
        2: e = $urandom_range(99) < prob;
        3: e = (cyc == fire_at);
        default: e = 1'b0;
      endcase
      sig_edge = e;
      sigc = sfn(cyc);
      refc = rfn(cyc);
      if (e) edge_q.push_back(cyc);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (gate === 1'b1) gate_cnt++;
      if (cnt_clr === 1'b1) clr_cnt++;
    end
  end

  // Reference model: timing derived from edge times, gate length and timeout.
  task automatic model(input int s, input int l, output int rep,
                       output int gl, output bit tm,
                       output logic [31:0] es, output logic [31:0] er);
    int a, le, e1, e2, c0, ce;
    le = (l == 0) ? 1 : l;
    a = s + 2;
    e1 = -1;
    e2 = -1;
    foreach (edge_q[i]) if (e1 < 0 && edge_q[i] >= a) e1 = edge_q[i];
    if (e1 < 0 || e1 > a + TMO) begin
      rep = a + TMO + 1;
      gl = 0;
      tm = 1'b1;
      es = '0;
      er = '0;
    end else begin
      c0 = e1 + le + 1;
      foreach (edge_q[i]) if (e2 < 0 && edge_q[i] >= c0) e2 = edge_q[i];
      if (e2 >= 0 && e2 <= c0 + TMO) begin
        ce = e2;
        tm = 1'b0;
      end else begin
        ce = c0 + TMO;
        tm = 1'b1;
      end
      gl = ce - e1;
      rep = ce + SET + 1;
      es = sfn(ce + SET);
      er = rfn(ce + SET);
    end
  endtask

  task automatic run_meas(input int l, input int hold, input bit poke,
                          input bit early);
    int s, n, rep, gl, gb, cb;
    bit tm;
    logic [31:0] es, er;
    ready = early;
    @(posedge clk);
    #2;
    start = 1'b1;
    glen = 24'(l);
    s = cyc;
    gb = gate_cnt;
    cb = clr_cnt;
    @(posedge clk);
    #2;
    start = 1'b0;
    n = 0;
    while (valid !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 3000) begin
      bad++;
      $display("FAIL wait_valid got=none exp=valid within 3000");
      return;
    end
    model(s, l, rep, gl, tm, es, er);
    total++;
    if (cyc !== rep) begin
      bad++;
      $display("FAIL report_cycle got=%0d exp=%0d", cyc - s, rep - s);
    end
    total++;
    if (gate_cnt - gb !== gl) begin
      bad++;
      $display("FAIL gate_len got=%0d exp=%0d", gate_cnt - gb, gl);
    end
    total++;
    if (clr_cnt - cb !== 1) begin
      bad++;
      $display("FAIL clr_pulses got=%0d exp=1", clr_cnt - cb);
    end
    total++;
    if (tmo_flag !== tm) begin
      bad++;
      $display("FAIL timeout got=%0b exp=%0b", tmo_flag, tm);
    end
    total++;
    if (res_sig !== es || res_ref !== er) begin
      bad++;
      $display("FAIL counts got=%0d/%0d exp=%0d/%0d", res_sig, res_ref, es, er);
    end
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        start = poke && (i == 2);
        @(negedge clk);
        start = 1'b0;
        total++;
        if (valid !== 1'b1 || res_sig !== es || res_ref !== er ||
            tmo_flag !== tm) begin
          bad++;
          $display("FAIL hold_stable got=%0b/%0d/%0d exp=1/%0d/%0d",
                   valid, res_sig, res_ref, es, er);
        end
      end
      ready = 1'b1;
    end
    @(negedge clk);
    total++;
    if (valid !== 1'b0 || state !== 3'd0) begin
      bad++;
      $display("FAIL handshake got=%0b/%0d exp=0/0", valid, state);
    end
    ready = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL stay_idle got=%0b exp=0", busy);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({gate, cnt_clr, valid, busy, tmo_flag} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=00000",
               {gate, cnt_clr, valid, busy, tmo_flag});
    end
    total++;
    if (state !== 3'd0 || res_sig !== '0 || res_ref !== '0) begin
      bad++;
      $display("FAIL reset_data got=%0d/%0d/%0d exp=0/0/0",
               state, res_sig, res_ref);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic();
    const_cnt = 1'b1;
    mode = 1;
    period = 5;
    run_meas(10, 2, 1'b0, 1'b0);
    const_cnt = 1'b0;
  endtask

  task automatic test_backpressure();
    mode = 2;
    prob = 25;
    run_meas(int'($urandom_range(12)) + 1, 20, 1'b1, 1'b0);
  endtask

  task automatic test_arm_timeout();
    mode = 0;
    run_meas(7, 3, 1'b0, 1'b0);
  endtask

  task automatic test_close_timeout();
    mode = 3;
    fire_at = cyc + 6;
    run_meas(5, 1, 1'b0, 1'b0);
    mode = 0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      mode = ($urandom_range(1) == 0) ? 1 : 2;
      period = int'($urandom_range(9, 2));
      prob = int'($urandom_range(60, 5));
      run_meas(int'($urandom_range(15)), int'($urandom_range(5)),
               1'b0, 1'($urandom_range(1)));
    end
  endtask

  task automatic test_mid_reset();
    int n, vc;
    bit g;
    mode = 1;
    period = 4;
    @(posedge clk);
    #2;
    start = 1'b1;
    glen = 24'd20;
    @(posedge clk);
    #2;
    start = 1'b0;
    n = 0;
    while (state !== 3'd3 && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 300) begin
      bad++;
      $display("FAIL reach_gate got=%0d exp=3", state);
    end
    @(negedge clk);
    g = gate;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (g !== 1'b1) begin
      bad++;
      $display("FAIL gate_open got=%0b exp=1", g);
    end
    total++;
    if ({gate, busy, valid} !== 3'b0 || state !== 3'd0) begin
      bad++;
      $display("FAIL async_reset got=%b/%0d exp=000/0",
               {gate, busy, valid}, state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    vc = 0;
    repeat (150) begin
      @(negedge clk);
      if (valid !== 1'b0 || busy !== 1'b0) vc++;
    end
    total++;
    if (vc !== 0) begin
      bad++;
      $display("FAIL post_reset_quiet got=%0d exp=0", vc);
    end
    mode = 0;
  endtask

`ifdef CONTINUOUS_MODE_EN
  task automatic test_continuous();
    int nres, n, q;
    bit prev;
    nres = 0;
    n = 0;
    prev = 1'b0;
    mode = 1;
    period = 4;
    ready = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b1;
    glen = 24'd3;
    @(posedge clk);
    #2;
    start = 1'b0;
    while (nres < 3 && n < 3000) begin
      @(negedge clk);
      n++;
      if (valid === 1'b1 && !prev) nres++;
      if (nres == 2 && valid !== 1'b1) ready = 1'b0;
      prev = (valid === 1'b1);
    end
    total++;
    if (nres !== 3) begin
      bad++;
      $display("FAIL cont_results got=%0d exp=3", nres);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    total++;
    if (state !== 3'd0) begin
      bad++;
      $display("FAIL cont_stop got=%0d exp=0", state);
    end
    q = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy !== 1'b0) q++;
    end
    total++;
    if (q !== 0) begin
      bad++;
      $display("FAIL cont_idle got=%0d exp=0", q);
    end
    mode = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_arm_timeout();
    test_close_timeout();
    test_random();
`ifdef CONTINUOUS_MODE_EN
    test_continuous();
`endif
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
